// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between instruction fetch and the EX load/store port.
// Read data returns one cycle after the grant, routed by the registered read owner.
module mem_port_arbiter #(
  parameter int MAX_D_RUN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_re_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [2:0]  d_size_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        d_ack_o,
  output logic        if_stall_o,
  output logic        d_stall_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [2:0]  ram_size_o,
  input  logic [31:0] ram_rdata_i,
  output logic [1:0]  dbg_rd_owner_o,
  output logic [2:0]  dbg_run_cnt_o
);

  // Requests are level signals held by the requester until granted (valid without
  // a ready back-pressure path): a grant in a cycle is the acceptance for that cycle.
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } rd_owner_e;

  localparam logic [2:0] MAX_RUN = 3'(MAX_D_RUN);

  rd_owner_e  rd_owner_q, rd_owner_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       d_req, d_gnt, f_gnt;

  // Grants are gated by rst_n so every derived output is 0 while reset is held.
  always_comb begin
    d_req = d_re_i | d_we_i;
    d_gnt = rst_n & d_req & (~if_req_i | (run_cnt_q != MAX_RUN));
    f_gnt = rst_n & if_req_i & ~d_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= OWN_IDLE;
      run_cnt_q  <= 3'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_comb begin
    rd_owner_d = OWN_IDLE;
    if (f_gnt)                rd_owner_d = OWN_FETCH;
    else if (d_gnt && !d_we_i) rd_owner_d = OWN_DATA;

    run_cnt_d = 3'd0;
    if (d_gnt && if_req_i)
      run_cnt_d = (run_cnt_q == MAX_RUN) ? MAX_RUN : run_cnt_q + 3'd1;
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = 32'd0;
    ram_wdata_o = 32'd0;
    ram_size_o  = 3'd0;
    if (d_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_addr_o  = d_addr_i;
      ram_wdata_o = d_wdata_i;
      ram_size_o  = d_size_i;
    end else if (f_gnt) begin
      ram_en_o   = 1'b1;
      ram_addr_o = if_addr_i;
      ram_size_o = 3'b010;
    end

    d_ack_o    = d_gnt;
    if_stall_o = rst_n & if_req_i & ~f_gnt;
    d_stall_o  = rst_n & d_req & ~d_gnt;

    if_valid_o = 1'b0;
    if_rdata_o = 32'd0;
    d_valid_o  = 1'b0;
    d_rdata_o  = 32'd0;
    if (rst_n && rd_owner_q == OWN_FETCH) begin
      if_valid_o = 1'b1;
      if_rdata_o = ram_rdata_i;
    end else if (rst_n && rd_owner_q == OWN_DATA) begin
      d_valid_o = 1'b1;
      d_rdata_o = ram_rdata_i;
    end

    dbg_rd_owner_o = rd_owner_q;
    dbg_run_cnt_o  = run_cnt_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation and reset sequences,
// then random traffic against a grant/response reference model.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;

  logic        clk, rst_n;
  logic        if_req_i, d_re_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, ram_rdata_i;
  logic [2:0]  d_size_i;
  logic [31:0] if_rdata_o, d_rdata_o, ram_addr_o, ram_wdata_o;
  logic        if_valid_o, d_valid_o, d_ack_o, if_stall_o, d_stall_o, ram_en_o, ram_we_o;
  logic [2:0]  ram_size_o, dbg_run_cnt_o;
  logic [1:0]  dbg_rd_owner_o;

  mem_port_arbiter #(.MAX_D_RUN(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .d_re_i(d_re_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_ack_o(d_ack_o),
    .if_stall_o(if_stall_o), .d_stall_o(d_stall_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_size_o(ram_size_o), .ram_rdata_i(ram_rdata_i),
    .dbg_rd_owner_o(dbg_rd_owner_o), .dbg_run_cnt_o(dbg_run_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: owner of the response due next cycle (0 none, 1 fetch, 2 data)
  logic [1:0] exp_q[$];
  int run_m = 0;

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dre, dwe;
    logic [31:0] da, dw;
    logic [2:0]  ds;
    logic [31:0] rd;
    int          g;
    int          eifv, edv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram"}, {ram_en_o, ram_we_o, ram_size_o} , 32'd0);
    chk({tag, "_addr"}, ram_addr_o | ram_wdata_o, 32'd0);
    chk({tag, "_ctl"}, {if_valid_o, d_valid_o, d_ack_o, if_stall_o, d_stall_o}, 32'd0);
    chk({tag, "_rdata"}, if_rdata_o | d_rdata_o, 32'd0);
    chk({tag, "_run"}, dbg_run_cnt_o, 32'd0);
  endtask

  // driver + model: entered just after a negedge, returns just after the next negedge
  task automatic step(input logic ifr, input logic [31:0] ifa, input logic dre, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dw, input logic [2:0] ds,
                      input logic [31:0] rd, input int exp_g, input int eifv, input int edv);
    int g, own, obs_g;
    logic dreq;
    if_req_i = ifr; if_addr_i = ifa; d_re_i = dre; d_we_i = dwe;
    d_addr_i = da; d_wdata_i = dw; d_size_i = ds; ram_rdata_i = rd;
    #1;
    dreq = dre | dwe;
    if (dreq && ifr) g = (run_m >= MAXR) ? 1 : 2;
    else if (dreq)   g = 2;
    else if (ifr)    g = 1;
    else             g = 0;
    own = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;

    obs_g = d_ack_o ? 2 : (ram_en_o ? 1 : 0);
    if (exp_g >= 0) chk("tbl_grant", obs_g, exp_g);
    if (eifv >= 0)  chk("tbl_if_valid", if_valid_o, eifv);
    if (edv >= 0)   chk("tbl_d_valid", d_valid_o, edv);
    chk("grant", obs_g, g);
    chk("ram_en", ram_en_o, g != 0);
    chk("ram_we", ram_we_o, (g == 2) && dwe);
    chk("ram_addr", ram_addr_o, (g == 2) ? da : (g == 1) ? ifa : 32'd0);
    chk("ram_wdata", ram_wdata_o, (g == 2) ? dw : 32'd0);
    chk("ram_size", ram_size_o, (g == 2) ? ds : (g == 1) ? 3'b010 : 3'b000);
    chk("if_stall", if_stall_o, ifr && (g != 1));
    chk("d_stall", d_stall_o, dreq && (g != 2));
    chk("if_valid", if_valid_o, own == 1);
    chk("if_rdata", if_rdata_o, (own == 1) ? rd : 32'd0);
    chk("d_valid", d_valid_o, own == 2);
    chk("d_rdata", d_rdata_o, (own == 2) ? rd : 32'd0);
    chk("run_cnt", dbg_run_cnt_o, run_m);

    @(posedge clk);
    if (g == 2 && ifr) run_m = (run_m + 1 > MAXR) ? MAXR : run_m + 1;
    else               run_m = 0;
    exp_q.push_back((g == 1) ? 2'd1 : (g == 2 && !dwe) ? 2'd2 : 2'd0);
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'h0, 1, 0, 0};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'h00500093, 0, 1, 0};
    tbl[2] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 3'd2, 32'h0, 2, 0, 0};
    tbl[3] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'hDEADBEEF, 1, 0, 1};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2004, 32'h12345678, 3'b010, 32'h11, 2, 1, 0};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'h22, 0, 0, 0};

    // reset with requests active: everything must read 0
    rst_n = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h40; d_re_i = 1'b1; d_we_i = 1'b1;
    d_addr_i = 32'h80; d_wdata_i = 32'hA5A5A5A5; d_size_i = 3'd2; ram_rdata_i = 32'hFFFF0000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    run_m = 0;

    for (int i = 0; i < 6; i++)
      step(tbl[i].ifr, tbl[i].ifa, tbl[i].dre, tbl[i].dwe, tbl[i].da, tbl[i].dw, tbl[i].ds,
           tbl[i].rd, tbl[i].g, tbl[i].eifv, tbl[i].edv);

    // starvation: loads and fetch both asserted -> D,D,D,D,F,D,D,D,D,F
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h200, 1'b1, 1'b0, 32'h3000 + 32'(i * 4), 32'h0, 3'd2, 32'h1000 + 32'(i),
           (i % 5 == 4) ? 1 : 2, -1, -1);

    // interleaved fetch/load grants with distinct RAM data
    for (int i = 0; i < 6; i++)
      step(i % 2 == 0, 32'h300 + 32'(i * 4), i % 2 == 1, 1'b0, 32'h4000 + 32'(i * 4), 32'h0,
           3'd2, 32'hC0DE0000 + 32'(i), (i % 2 == 0) ? 1 : 2, (i > 0 && i % 2 == 0) ? 0 : -1, -1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'hC0DE00FF, 0, 0, 1);

    // reset while a load response is in flight
    if_req_i = 1'b0; d_re_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h5000; ram_rdata_i = 32'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    if_req_i = 1'b1; ram_rdata_i = 32'hBAD0BAD0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    run_m = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 32'hBAD0BAD0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic ifr, dre, dwe;
      ifr = ($urandom_range(0, 3) != 0);
      dre = ($urandom_range(0, 2) != 0);
      dwe = ($urandom_range(0, 3) == 0);
      step(ifr, {$urandom_range(0, 1023), 2'b00}, dre, dwe, $urandom, $urandom,
           3'($urandom_range(0, 7)), $urandom, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
